// File: rtl/nibble_sub_sequencer.sv
// nibble_sub_sequencer: 16-bit a-b-bin, one nibble per cycle on an external 4-bit subtractor
//   clk, rst (sync, active-high)
//   in_valid/in_ready, op_a, op_b, op_bin   : operand handshake
//   out_valid/out_ready, res_diff, res_bout : result handshake (held in DONE)
//   sub_a, sub_b, sub_in_borrow             : drive to external subtractor (0 outside RUN)
//   sub_difference, sub_out_borrow          : combinational return from external subtractor
//   SUB_SEQ_FLAGS_EN adds res_zero and res_ovf, captured on the final RUN edge
module nibble_sub_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        op_bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] res_diff,
  output logic        res_bout,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic        sub_in_borrow,
  input  logic [3:0]  sub_difference,
  input  logic        sub_out_borrow
`ifdef SUB_SEQ_FLAGS_EN
  ,
  output logic        res_zero,
  output logic        res_ovf
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [15:0] a_q, b_q;
  logic        bin_q, brw;
  logic [1:0]  idx;
  logic        run;
  assign run           = state == RUN;
  assign in_ready      = state == IDLE && !rst;
  assign out_valid     = state == DONE;
  assign sub_a         = run ? a_q[{idx, 2'b00} +: 4] : 4'h0;
  assign sub_b         = run ? b_q[{idx, 2'b00} +: 4] : 4'h0;
  assign sub_in_borrow = run && (idx == 2'd0 ? bin_q : brw);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      brw      <= 1'b0;
      a_q      <= 16'h0;
      b_q      <= 16'h0;
      bin_q    <= 1'b0;
      res_diff <= 16'h0;
      res_bout <= 1'b0;
`ifdef SUB_SEQ_FLAGS_EN
      res_zero <= 1'b0;
      res_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= op_a;
          b_q   <= op_b;
          bin_q <= op_bin;
          idx   <= 2'd0;
          state <= RUN;
        end
        RUN: begin
          res_diff[{idx, 2'b00} +: 4] <= sub_difference;
          brw <= sub_out_borrow;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            res_bout <= sub_out_borrow;
            state    <= DONE;
`ifdef SUB_SEQ_FLAGS_EN
            // top nibble is still arriving, so build the final word here
            res_zero <= {sub_difference, res_diff[11:0]} == 16'h0;
            res_ovf  <= (a_q[15] ^ b_q[15]) & (sub_difference[3] ^ a_q[15]);
`endif
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_sub_sequencer.sv
// tb_nibble_sub_sequencer: table-driven scoreboard bench with a behavioural 4-bit subtractor
module tb_nibble_sub_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, op_bin;
  logic [15:0] op_a, op_b;
  logic        in_ready, out_valid, res_bout, sub_in_borrow, sub_out_borrow;
  logic [15:0] res_diff;
  logic [3:0]  sub_a, sub_b, sub_difference;
`ifdef SUB_SEQ_FLAGS_EN
  logic        res_zero, res_ovf;
`endif
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;
  vec_t tbl[9];
  vec_t sbq[$];
  always #5 clk = ~clk;
  // external 4-bit subtractor: 5-bit result, bit 4 is the borrow-out
  logic [4:0] ext;
  assign ext            = {1'b0, sub_a} - {1'b0, sub_b} - {4'h0, sub_in_borrow};
  assign sub_difference = ext[3:0];
  assign sub_out_borrow = ext[4];
  nibble_sub_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_bin(op_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_diff(res_diff), .res_bout(res_bout),
    .sub_a(sub_a), .sub_b(sub_b), .sub_in_borrow(sub_in_borrow),
    .sub_difference(sub_difference), .sub_out_borrow(sub_out_borrow)
`ifdef SUB_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_ovf(res_ovf)
`endif
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // starts at a negedge with the DUT in IDLE; ends at a negedge back in IDLE
  task automatic run_op(input vec_t v, input int hold);
    vec_t e;
    logic [15:0] ta, tb;
    int n;
    #1;
    chk("in_ready_idle", in_ready, 1);
    chk("sub_a_idle", sub_a, 0);
    op_a = v.a; op_b = v.b; op_bin = v.bin; in_valid = 1;
    out_ready = hold == 0;
    @(posedge clk);
    sbq.push_back(v);
    @(negedge clk);
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      ta = v.a >> (4 * k);
      tb = v.b >> (4 * k);
      chk("sub_a_run", sub_a, ta[3:0]);
      chk("sub_b_run", sub_b, tb[3:0]);
      if (k == 0) chk("sub_in_borrow_idx0", sub_in_borrow, v.bin);
      chk("out_valid_early", out_valid, 0);
      chk("in_ready_run", in_ready, 0);
      @(negedge clk);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency_extra_cycles", n, 0);
    if (sbq.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = sbq.pop_front();
      chk("res_diff", res_diff, e.diff);
      chk("res_bout", res_bout, e.bout);
      chk("sub_a_done", sub_a, 0);
`ifdef SUB_SEQ_FLAGS_EN
      chk("res_zero", res_zero, e.zero);
      chk("res_ovf", res_ovf, e.ovf);
`endif
      for (int h = 0; h < hold; h++) begin
        op_a = ~v.a; op_b = 16'h0001; in_valid = 1;
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_res_diff", res_diff, e.diff);
        chk("hold_res_bout", res_bout, e.bout);
      end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    out_ready = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};
    rst = 1; in_valid = 0; out_ready = 0; op_a = 0; op_b = 0; op_bin = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res_diff", res_diff, 0);
    chk("rst_res_bout", res_bout, 0);
    chk("rst_sub_a", sub_a, 0);
    chk("rst_sub_in_borrow", sub_in_borrow, 0);
`ifdef SUB_SEQ_FLAGS_EN
    chk("rst_res_zero", res_zero, 0);
    chk("rst_res_ovf", res_ovf, 0);
`endif
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_op(tbl[i], i == 1 ? 3 : 0);
    chk("idle_holds_res", res_diff, 16'h9999);
    op_a = 16'h1234; op_b = 16'h0234; op_bin = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_sub_a_idx2", sub_a, 4'h2);
    rst = 1;
    @(negedge clk);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_res_diff", res_diff, 0);
    chk("midrun_rst_res_bout", res_bout, 0);
    chk("midrun_rst_sub_a", sub_a, 0);
    chk("midrun_rst_sub_in_borrow", sub_in_borrow, 0);
    chk("midrun_rst_in_ready", in_ready, 0);
    rst = 0;
    @(negedge clk);
    run_op('{16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0}, 0);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
